// File: rtl/add_one_pkg.sv
// Shared word type and increment for the add-one channel pair.
// ADD_ONE_SAT_EN selects a saturating increment instead of a modulo wrap.
package add_one_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    typedef logic [DATA_W-1:0] word_t;

    function automatic word_t inc_word(input word_t x);
`ifdef ADD_ONE_SAT_EN
        return (&x) ? x : x + word_t'(1);
`else
        return x + word_t'(1);
`endif
    endfunction

endpackage

// File: rtl/p2p_fifo.sv
// Generic DEPTH x W synchronous FIFO for point-to-point channels.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: push is ignored while full and pop is ignored while empty; there is no bypass.
module p2p_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/add_one_responder.sv
// Add-one responder: accepts x, returns x+1 in order (saturating when ADD_ONE_SAT_EN is defined).
// Latency: result valid the cycle after the operand is accepted into an empty FIFO.
// Backpressure: x_in_busy while in the first cycle after reset or while the result FIFO is full.
module add_one_responder
    import add_one_pkg::*;
#(
    parameter int DATA_W = add_one_pkg::DATA_W,
    parameter int DEPTH  = add_one_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              add_one_x_in_busy,
    input  logic              add_one_x_in_vld,
    input  logic [DATA_W-1:0] add_one_x_in_data,
    input  logic              add_one_return_out_busy,
    output logic              add_one_return_out_vld,
    output logic [DATA_W-1:0] add_one_return_out_data
);

    logic                    init_q, init_d;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop;
    logic [DATA_W-1:0]       push_dat;
    logic [$clog2(DEPTH):0]  fifo_count_unused;

    always_comb begin
        init_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q <= 1'b1;
        end else begin
            init_q <= init_d;
        end
    end

    // A full FIFO blocks pushes even on a pop edge: busy is purely registered state.
    assign add_one_x_in_busy      = init_q | fifo_full;
    assign add_one_return_out_vld = ~fifo_empty;

    assign push     = add_one_x_in_vld & ~add_one_x_in_busy;
    assign pop      = add_one_return_out_vld & ~add_one_return_out_busy;
    assign push_dat = DATA_W'(inc_word(word_t'(add_one_x_in_data)));

    p2p_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (add_one_return_out_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count_unused)
    );

endmodule

// File: tb/tb_add_one_responder.sv
// Bench for add_one_responder: directed scenarios plus randomized traffic against a queue model.
module tb_add_one_responder;

    localparam int DEPTH_M = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_vld;
    logic [31:0] x_dat;
    logic        ret_busy;
    logic        x_busy;
    logic        ret_vld;
    logic [31:0] ret_dat;

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];
    bit          init_m = 1'b1;

    always #5 clk = ~clk;

    add_one_responder dut (
        .clk                     (clk),
        .rst                     (rst),
        .add_one_x_in_busy       (x_busy),
        .add_one_x_in_vld        (x_vld),
        .add_one_x_in_data       (x_dat),
        .add_one_return_out_busy (ret_busy),
        .add_one_return_out_vld  (ret_vld),
        .add_one_return_out_data (ret_dat)
    );

    function automatic logic [31:0] ref_inc(input logic [31:0] x);
`ifdef ADD_ONE_SAT_EN
        if (x == 32'hFFFF_FFFF) return x;
`endif
        return x + 32'd1;
    endfunction

    function automatic logic [33:0] model_out();
        logic        b;
        logic        v;
        logic [31:0] d;
        b = init_m || (mq.size() == DEPTH_M);
        v = (mq.size() != 0);
        d = v ? mq[0] : 32'd0;
        return {b, v, d};
    endfunction

    // Advance one clock edge; the model applies the transfer rules to the inputs held at that edge.
    task automatic tick();
        bit acc;
        bit rel;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            init_m = 1'b1;
        end else begin
            acc = x_vld && !(init_m || mq.size() == DEPTH_M);
            rel = (mq.size() != 0) && !ret_busy;
            if (rel) void'(mq.pop_front());
            if (acc) mq.push_back(ref_inc(x_dat));
            init_m = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; x_vld = 1'b1; x_dat = 32'h1234; ret_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({x_busy, ret_vld, ret_dat} !== {1'b1, 1'b0, 32'd0}) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got busy=%b vld=%b dat=%h want busy=1 vld=0 dat=0",
                         i, x_busy, ret_vld, ret_dat);
            end
        end
        rst = 1'b0; x_vld = 1'b0;
        tick();
        total++;
        if ({x_busy, ret_vld, ret_dat} !== {1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset_release got busy=%b vld=%b dat=%h want busy=0 vld=0 dat=0",
                     x_busy, ret_vld, ret_dat);
        end
    endtask

    task automatic test_single();
        ret_busy = 1'b0; x_vld = 1'b1; x_dat = 32'h0000_0007;
        #1;
        total++;
        if (ret_vld !== 1'b0) begin
            bad++;
            $display("FAIL single_no_comb got vld=%b want 0", ret_vld);
        end
        tick();
        total++;
        if ({x_busy, ret_vld, ret_dat} !== {1'b0, 1'b1, 32'h0000_0008}) begin
            bad++;
            $display("FAIL single_result got busy=%b vld=%b dat=%h want busy=0 vld=1 dat=00000008",
                     x_busy, ret_vld, ret_dat);
        end
        x_vld = 1'b0;
        tick();
        total++;
        if ({ret_vld, ret_dat} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL single_drain got vld=%b dat=%h want vld=0 dat=0", ret_vld, ret_dat);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] want [6];
        want[0] = {1'b0, 1'b1, 32'h11};
        want[1] = {1'b1, 1'b1, 32'h11};
        want[2] = {1'b1, 1'b1, 32'h11};
        want[3] = {1'b0, 1'b1, 32'h21};
        want[4] = {1'b0, 1'b1, 32'h31};
        want[5] = {1'b0, 1'b0, 32'h0};
        ret_busy = 1'b1; x_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x_dat    = (i == 0) ? 32'h10 : (i == 1) ? 32'h20 : 32'h30;
            ret_busy = (i < 3);
            x_vld    = (i < 5);
            tick();
            total++;
            if ({x_busy, ret_vld, ret_dat} !== want[i]) begin
                bad++;
                $display("FAIL backpressure step=%0d got busy=%b vld=%b dat=%h want busy=%b vld=%b dat=%h",
                         i, x_busy, ret_vld, ret_dat, want[i][33], want[i][32], want[i][31:0]);
            end
        end
    endtask

    task automatic test_full_pop();
        ret_busy = 1'b1; x_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x_dat    = $urandom;
            ret_busy = (i < 3);
            x_vld    = (i < 5);
            tick();
            total++;
            if ({x_busy, ret_vld, ret_dat} !== model_out()) begin
                bad++;
                $display("FAIL full_pop step=%0d got busy=%b vld=%b dat=%h want %h",
                         i, x_busy, ret_vld, ret_dat, model_out());
            end
            total++;
            if (i == 3 && (x_busy !== 1'b0 || mq.size() != 1)) begin
                bad++;
                $display("FAIL full_pop_nobypass got busy=%b depth=%0d want busy=0 depth=1",
                         x_busy, mq.size());
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want_w;
`ifdef ADD_ONE_SAT_EN
        want_w = 32'hFFFF_FFFF;
`else
        want_w = 32'h0000_0000;
`endif
        ret_busy = 1'b0; x_vld = 1'b1; x_dat = 32'hFFFF_FFFF;
        tick();
        x_vld = 1'b0;
        total++;
        if ({ret_vld, ret_dat} !== {1'b1, want_w}) begin
            bad++;
            $display("FAIL wrap got vld=%b dat=%h want vld=1 dat=%h", ret_vld, ret_dat, want_w);
        end
        tick();
    endtask

    task automatic test_midrun_reset();
        ret_busy = 1'b1; x_vld = 1'b1;
        x_dat = 32'hA; tick();
        x_dat = 32'hB; tick();
        rst = 1'b1; x_vld = 1'b0;
        tick();
        total++;
        if ({x_busy, ret_vld, ret_dat} !== {1'b1, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL midrun_reset got busy=%b vld=%b dat=%h want busy=1 vld=0 dat=0",
                     x_busy, ret_vld, ret_dat);
        end
        rst = 1'b0;
        tick();
        ret_busy = 1'b0; x_vld = 1'b1; x_dat = 32'h5;
        tick();
        x_vld = 1'b0;
        total++;
        if ({x_busy, ret_vld, ret_dat} !== {1'b0, 1'b1, 32'h6}) begin
            bad++;
            $display("FAIL midrun_after got busy=%b vld=%b dat=%h want busy=0 vld=1 dat=00000006",
                     x_busy, ret_vld, ret_dat);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            x_vld    = ($urandom_range(0, 3) != 0);
            ret_busy = ($urandom_range(0, 2) == 0);
            x_dat    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            tick();
            total++;
            if ({x_busy, ret_vld, ret_dat} !== model_out()) begin
                bad++;
                $display("FAIL random cyc=%0d got busy=%b vld=%b dat=%h want %h",
                         i, x_busy, ret_vld, ret_dat, model_out());
            end
        end
        rst = 1'b0; x_vld = 1'b0; ret_busy = 1'b0;
        tick(); tick(); tick();
        total++;
        if (ret_vld !== 1'b0 || mq.size() != 0) begin
            bad++;
            $display("FAIL random_drain got vld=%b model_depth=%0d want vld=0 depth=0", ret_vld, mq.size());
        end
    endtask

    initial begin
        rst = 1'b1; x_vld = 1'b0; x_dat = '0; ret_busy = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_midrun_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
